// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake plus the nibble-wide link to an external
// FourBitSubtractor. The slave side is the sequencer; the master side is
// whoever supplies operands, consumes results and hosts the 4-bit subtractor.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             borrowIn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrowOut;
  logic [3:0]       sub_x;
  logic [3:0]       sub_y;
  logic             sub_bin;
  logic [3:0]       sub_xy;
  logic             sub_bout;

  modport master (
    output in_valid, x, y, borrowIn, out_ready, sub_xy, sub_bout,
    input  in_ready, out_valid, diff, borrowOut, sub_x, sub_y, sub_bin
  );

  modport slave (
    input  in_valid, x, y, borrowIn, out_ready, sub_xy, sub_bout,
    output in_ready, out_valid, diff, borrowOut, sub_x, sub_y, sub_bin
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial sequencer for an external 4-bit ripple-borrow subtractor.
// One WIDTH-bit subtraction per accept: operands are walked LSB nibble first,
// the borrow is carried in a register between nibbles, and the assembled
// {borrowOut, diff} = x - y - borrowIn is held on a valid/ready output.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      nReset,
  nibble_serial_subtractor_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] xr, yr, res;
  logic             bin_r;
  logic             brw;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             bout_r;
  logic [IW+1:0]    base;

  // Bit offset of the nibble currently being worked on.
  assign base = {idx, 2'b00};

  // Sequencer FSM; handshake flags and the final borrow are registered here.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      idx         <= '0;
      xr          <= '0;
      yr          <= '0;
      res         <= '0;
      bin_r       <= 1'b0;
      brw         <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      bout_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xr         <= bus.x;
            yr         <= bus.y;
            bin_r      <= bus.borrowIn;
            res        <= '0;
            brw        <= 1'b0;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          res[base +: 4] <= bus.sub_xy;
          brw            <= bus.sub_bout;
          if (idx == LAST) begin
            // Borrow out of the top nibble is the overall borrow.
            bout_r      <= bus.sub_bout;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            res         <= '0;
            brw         <= 1'b0;
            bout_r      <= 1'b0;
            idx         <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Subtractor feed is only live in RUN; elsewhere it idles at zero.
  always_comb begin
    bus.sub_x   = 4'h0;
    bus.sub_y   = 4'h0;
    bus.sub_bin = 1'b0;
    if (state == RUN) begin
      bus.sub_x   = xr[base +: 4];
      bus.sub_y   = yr[base +: 4];
      bus.sub_bin = (idx == '0) ? bin_r : brw;
    end
  end

  // diff shows the assembly register; it is only meaningful with out_valid.
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = res;
  assign bus.borrowOut = bout_r;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor at WIDTH=16 with a behavioural 4-bit
// ripple-borrow subtractor hooked to the sub_* link.
module tb_nibble_serial_subtractor;
  localparam int WIDTH = 16;

  logic clk;
  logic nReset;

  nibble_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  // FourBitSubtractor: xy = x - y - bin, borrowOut from bit 4.
  logic [4:0] nib;
  assign nib          = {1'b0, bus.sub_x} - {1'b0, bus.sub_y} - {4'b0, bus.sub_bin};
  assign bus.sub_xy   = nib[3:0];
  assign bus.sub_bout = nib[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic [15:0] d;
    logic        b;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        b;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Independent 17-bit reference: {borrow, diff} = {0,x} - y - bin.
  function automatic exp_t ref_model(input logic [15:0] x, input logic [15:0] y, input logic bin);
    logic [16:0] r;
    exp_t e;
    r   = {1'b0, x} - {1'b0, y} - {16'b0, bin};
    e.d = r[15:0];
    e.b = r[16];
    return e;
  endfunction

  // Wait for in_ready (bounded), present operands, accept on next edge.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic bin, input bit push);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.x        = x;
    bus.y        = y;
    bus.borrowIn = bin;
    if (push) sb.push_back(ref_model(x, y, bin));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges to out_valid, compare against scoreboard, then drain.
  task automatic finish_op(input string name, input bit lat_chk, input bit drain);
    int   n = 0;
    exp_t e;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (lat_chk) chk({name, "_latency"}, n, 4);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({name, "_diff"}, bus.diff, e.d);
    chk({name, "_bout"}, bus.borrowOut, e.b);
    if (drain) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] sd;
    logic        sbo;
    int          rnd_bad;
    exp_t        e;

    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.borrowIn  = 1'b0;
    bus.out_ready = 1'b0;
    nReset        = 1'b0;

    vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vt[2] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1};
    vt[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};
    vt[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vt[5] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
    vt[6] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_bout", bus.borrowOut, 0);
    chk("rst_sub", {bus.sub_x, bus.sub_y, bus.sub_bin}, 0);
    nReset = 1'b1;
    @(posedge clk); #1;

    // Directed table: expected values written in the table itself.
    for (int i = 0; i < 7; i++) begin
      start_op(vt[i].x, vt[i].y, vt[i].bin, 1'b0);
      sb.push_back('{vt[i].d, vt[i].b});
      finish_op($sformatf("vec%0d", i), 1'b1, 1'b0);
      chk($sformatf("vec%0d_in_ready_done", i), bus.in_ready, 0);
      chk($sformatf("vec%0d_sub_done", i), {bus.sub_x, bus.sub_y, bus.sub_bin}, 0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk($sformatf("vec%0d_ov_clr", i), bus.out_valid, 0);
      chk($sformatf("vec%0d_diff_clr", i), bus.diff, 0);
      chk($sformatf("vec%0d_in_ready_back", i), bus.in_ready, 1);
    end

    // Backpressure: DONE holds 10 cycles unchanged; in_valid ignored there.
    start_op(16'h5A5A, 16'h1111, 1'b1, 1'b1);
    finish_op("bp", 1'b1, 1'b0);
    sd  = bus.diff;
    sbo = bus.borrowOut;
    bus.in_valid = 1'b1;
    bus.x        = 16'h7777;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", c), {bus.out_valid, bus.in_ready, bus.borrowOut, bus.diff},
          {1'b1, 1'b0, sbo, sd});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_idle", {bus.out_valid, bus.in_ready}, 2'b01);

    // out_ready asserted outside DONE must be ignored.
    bus.out_ready = 1'b1;
    start_op(16'h0F0F, 16'h00F0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    finish_op("ordy_early", 1'b1, 1'b1);

    // New operands held on in_valid during RUN are ignored until IDLE.
    start_op(16'h4321, 16'h0321, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    bus.x        = 16'h0001;
    bus.y        = 16'h0002;
    bus.borrowIn = 1'b0;
    sb.push_back(ref_model(16'h0001, 16'h0002, 1'b0));
    finish_op("busy_first", 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("busy_idle_again", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("busy_second_accepted", bus.in_ready, 0);
    finish_op("busy_second", 1'b0, 1'b1);

    // Reset after two nibbles: everything back to reset values, no result.
    start_op(16'hFFFF, 16'h1234, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    nReset = 1'b0;
    #1;
    chk("midrst_out", {bus.out_valid, bus.borrowOut, bus.diff}, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_sub", {bus.sub_x, bus.sub_y, bus.sub_bin}, 0);
    @(posedge clk); #1;
    nReset = 1'b1;
    @(posedge clk); #1;
    start_op(16'h00FF, 16'h0F00, 1'b0, 1'b0);
    sb.push_back('{16'hF1FF, 1'b1});
    finish_op("postrst", 1'b1, 1'b1);

    // Random sweep against the reference model; one check per op.
    rnd_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] rx, ry;
      logic        rb;
      int          n;
      rx = 16'($urandom);
      ry = 16'($urandom);
      rb = 1'($urandom);
      start_op(rx, ry, rb, 1'b1);
      n = 0;
      while (!bus.out_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
      e = sb.pop_front();
      checks++;
      if (n != 4 || bus.diff !== e.d || bus.borrowOut !== e.b) begin
        failures++;
        rnd_bad++;
        if (rnd_bad <= 5)
          $display("FAIL rnd%0d: %h-%h-%b got %b/%h lat %0d expected %b/%h lat 4",
                   i, rx, ry, rb, bus.borrowOut, bus.diff, n, e.b, e.d);
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      while (!bus.out_ready) begin
        @(posedge clk); #1;
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
